// File: rtl/right_shift_unit.sv
// Registered 8-bit right barrel shifter (ROR / SRL / SRA) built from 2:1 and
// 3:1 mux primitives: three log-shift layers plus a large-shift override.

module rsu_mux2 (
  input  logic in0,
  input  logic in1,
  input  logic sel,
  output logic out
);
  assign out = sel ? in1 : in0;
endmodule

module rsu_mux3 (
  input  logic       in0,
  input  logic       in1,
  input  logic       in2,
  input  logic [1:0] sel,
  output logic       out
);
  always_comb begin
    case (sel)
      2'b10:   out = in1;
      2'b11:   out = in2;
      default: out = in0;
    endcase
  end
endmodule

module right_shift_unit (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       IN_VALID,
  input  logic [7:0] DATA1,
  input  logic [7:0] DATA2,
  input  logic [1:0] SETPIN,
  output logic [7:0] OUTPUT,
  output logic       OUT_VALID
);

  logic [7:0] w_s0, w_s1, w_s2, w_result;
  logic [0:0] w_fill0;
  logic [1:0] w_fill1;
  logic [3:0] w_fill2;
  logic [7:0] w_large_val;
  logic       w_large;

  logic [7:0] r_output;
  logic       r_out_valid;

  // Layer 0: shift by 1. The bit entering at the top is chosen per mode.
  for (genvar i = 0; i < 7; i++) begin : g_l0
    rsu_mux2 u_m (.in0(DATA1[i]), .in1(DATA1[i+1]), .sel(DATA2[0]), .out(w_s0[i]));
  end
  rsu_mux3 u_f0 (.in0(DATA1[0]), .in1(1'b0), .in2(DATA1[7]), .sel(SETPIN), .out(w_fill0[0]));
  rsu_mux2 u_l0_top (.in0(DATA1[7]), .in1(w_fill0[0]), .sel(DATA2[0]), .out(w_s0[7]));

  // Layer 1: shift by 2.
  for (genvar i = 0; i < 6; i++) begin : g_l1
    rsu_mux2 u_m (.in0(w_s0[i]), .in1(w_s0[i+2]), .sel(DATA2[1]), .out(w_s1[i]));
  end
  for (genvar j = 0; j < 2; j++) begin : g_l1_top
    rsu_mux3 u_f (.in0(w_s0[j]), .in1(1'b0), .in2(w_s0[7]), .sel(SETPIN), .out(w_fill1[j]));
    rsu_mux2 u_m (.in0(w_s0[6+j]), .in1(w_fill1[j]), .sel(DATA2[1]), .out(w_s1[6+j]));
  end

  // Layer 2: shift by 4.
  for (genvar i = 0; i < 4; i++) begin : g_l2
    rsu_mux2 u_m (.in0(w_s1[i]), .in1(w_s1[i+4]), .sel(DATA2[2]), .out(w_s2[i]));
  end
  for (genvar j = 0; j < 4; j++) begin : g_l2_top
    rsu_mux3 u_f (.in0(w_s1[j]), .in1(1'b0), .in2(w_s1[7]), .sel(SETPIN), .out(w_fill2[j]));
    rsu_mux2 u_m (.in0(w_s1[4+j]), .in1(w_fill2[j]), .sel(DATA2[2]), .out(w_s2[4+j]));
  end

  // Shift amounts of 8 or more: rotate keeps the mod-8 result, shifts saturate.
  assign w_large = |DATA2[7:3];
  for (genvar i = 0; i < 8; i++) begin : g_large
    rsu_mux3 u_f (.in0(w_s2[i]), .in1(1'b0), .in2(DATA1[7]), .sel(SETPIN), .out(w_large_val[i]));
    rsu_mux2 u_m (.in0(w_s2[i]), .in1(w_large_val[i]), .sel(w_large), .out(w_result[i]));
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_output    <= 8'h00;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= IN_VALID;
      if (IN_VALID) r_output <= w_result;
    end
  end

  assign OUTPUT    = r_output;
  assign OUT_VALID = r_out_valid;

endmodule

// File: tb/tb_right_shift_unit.sv
// Self-checking bench for right_shift_unit: directed vector table, timing and
// reset sequences, and an exhaustive sweep against a behavioural model.

module tb_right_shift_unit;

  logic       CLK;
  logic       RESET;
  logic       IN_VALID;
  logic [7:0] DATA1;
  logic [7:0] DATA2;
  logic [1:0] SETPIN;
  logic [7:0] OUTPUT;
  logic       OUT_VALID;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [7:0] exp;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC];

  right_shift_unit dut (
    .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .DATA1(DATA1), .DATA2(DATA2),
    .SETPIN(SETPIN), .OUTPUT(OUTPUT), .OUT_VALID(OUT_VALID)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [1:0] mode, input logic [7:0] d,
                                       input logic [7:0] amt);
    logic [15:0] dd;
    logic [7:0]  r;
    dd = {d, d};
    case (mode)
      2'b10:   r = (amt >= 8) ? 8'h00 : (d >> amt);
      2'b11:   r = (amt >= 8) ? {8{d[7]}} : 8'($signed(d) >>> amt);
      default: begin
        dd = dd >> amt[2:0];
        r  = dd[7:0];
      end
    endcase
    return r;
  endfunction

  // Drive on the falling edge, sample 1 time unit after the next rising edge.
  task automatic apply(input logic v, input logic [1:0] m, input logic [7:0] d1,
                       input logic [7:0] d2);
    @(negedge CLK);
    IN_VALID = v;
    SETPIN   = m;
    DATA1    = d1;
    DATA2    = d2;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    vecs[0]  = '{2'b00, 8'h99, 8'h01, 8'hCC};
    vecs[1]  = '{2'b00, 8'hC3, 8'h03, 8'h78};
    vecs[2]  = '{2'b00, 8'hF1, 8'h02, 8'h7C};
    vecs[3]  = '{2'b01, 8'hF1, 8'h23, 8'h3E};
    vecs[4]  = '{2'b11, 8'h99, 8'h00, 8'h99};
    vecs[5]  = '{2'b11, 8'h99, 8'h01, 8'hCC};
    vecs[6]  = '{2'b11, 8'hE0, 8'h03, 8'hFC};
    vecs[7]  = '{2'b11, 8'h80, 8'h07, 8'hFF};
    vecs[8]  = '{2'b11, 8'h80, 8'h48, 8'hFF};
    vecs[9]  = '{2'b10, 8'h99, 8'h01, 8'h4C};
    vecs[10] = '{2'b10, 8'h99, 8'h04, 8'h09};
    vecs[11] = '{2'b10, 8'h99, 8'h09, 8'h00};
    vecs[12] = '{2'b10, 8'hA5, 8'h00, 8'hA5};
    vecs[13] = '{2'b00, 8'hA5, 8'h00, 8'hA5};
    vecs[14] = '{2'b00, 8'hA5, 8'h08, 8'hA5};
    vecs[15] = '{2'b11, 8'h7F, 8'h07, 8'h00};
    vecs[16] = '{2'b11, 8'h7F, 8'hFF, 8'h00};
    vecs[17] = '{2'b10, 8'h80, 8'h07, 8'h01};
    vecs[18] = '{2'b00, 8'h01, 8'h80, 8'h01};
    vecs[19] = '{2'b01, 8'h81, 8'h04, 8'h18};

    RESET = 1'b0; IN_VALID = 1'b0; SETPIN = 2'b00; DATA1 = 8'h00; DATA2 = 8'h00;
    #2;
    check("reset_output", OUTPUT, 8'h00);
    check("reset_valid", {7'd0, OUT_VALID}, 8'h00);
    @(negedge CLK);
    RESET = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      apply(1'b1, vecs[i].mode, vecs[i].d1, vecs[i].d2);
      check($sformatf("vec%0d_out", i), OUTPUT, vecs[i].exp);
      check($sformatf("vec%0d_valid", i), {7'd0, OUT_VALID}, 8'h01);
    end

    // Idle cycle: result holds, valid drops, new operands ignored.
    apply(1'b1, 2'b00, 8'h99, 8'h01);
    check("pulse_out", OUTPUT, 8'hCC);
    apply(1'b0, 2'b10, 8'h55, 8'h02);
    check("hold_out", OUTPUT, 8'hCC);
    check("hold_valid", {7'd0, OUT_VALID}, 8'h00);
    apply(1'b0, 2'b11, 8'h80, 8'h01);
    check("hold2_out", OUTPUT, 8'hCC);

    // Asynchronous reset mid-cycle with a pending input that must be discarded.
    @(negedge CLK);
    IN_VALID = 1'b1; SETPIN = 2'b10; DATA1 = 8'hF0; DATA2 = 8'h01;
    #2;
    RESET = 1'b0;
    #1;
    check("async_rst_out", OUTPUT, 8'h00);
    check("async_rst_valid", {7'd0, OUT_VALID}, 8'h00);
    @(posedge CLK);
    #1;
    check("rst_discard_out", OUTPUT, 8'h00);
    check("rst_discard_valid", {7'd0, OUT_VALID}, 8'h00);
    @(negedge CLK);
    RESET = 1'b1;
    apply(1'b1, 2'b10, 8'hF0, 8'h01);
    check("post_rst_out", OUTPUT, 8'h78);
    check("post_rst_valid", {7'd0, OUT_VALID}, 8'h01);

    // Back-to-back sweep over every DATA1, DATA2[3:0] and mode.
    for (int m = 0; m < 4; m++) begin
      for (int d2 = 0; d2 < 16; d2++) begin
        for (int d1 = 0; d1 < 256; d1++) begin
          apply(1'b1, 2'(m), 8'(d1), 8'(d2));
          check($sformatf("sweep_m%0d_d1_%02h_d2_%0d", m, d1, d2), OUTPUT,
                model(2'(m), 8'(d1), 8'(d2)));
        end
      end
    end
    check("sweep_valid", {7'd0, OUT_VALID}, 8'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
